// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one single-ported, multi-cycle memory between the instruction-fetch
// port (M1) and the data port (M2). Each level request becomes one timed
// access: LATENCY cycles in ACCESS (strobe on the last one) followed by a
// single RESP cycle in which the served port sees busy low and valid data.
// The data port has priority; a fetch that has been passed over MAX_D_STREAK
// times in a row is forced through next.
//
// Ports
//   Clk, Reset_N          clock (rising edge), asynchronous active-low reset
//   readM1, address1      fetch request level and address
//   data1, M1busy         fetched word, fetch stall
//   readM2, writeM2       data read / write request levels (write wins)
//   address2, data2       data address; data2 is write data in, read data out
//   M2busy                data stall
//   mem_read, mem_write   one-cycle memory strobes
//   mem_address, mem_wdata, mem_rdata   memory bus (rdata combinational)
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
   parameter int WORD_SIZE    = 16,
   parameter int LATENCY      = 4,
   parameter int MAX_D_STREAK = 2
) (
   input  logic                 Clk,
   input  logic                 Reset_N,
   input  logic                 readM1,
   input  logic [WORD_SIZE-1:0] address1,
   output logic [WORD_SIZE-1:0] data1,
   output logic                 M1busy,
   input  logic                 readM2,
   input  logic                 writeM2,
   input  logic [WORD_SIZE-1:0] address2,
   inout  wire  [WORD_SIZE-1:0] data2,
   output logic                 M2busy,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [WORD_SIZE-1:0] mem_address,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata
);

   localparam int CW = $clog2(LATENCY) + 1;
   localparam int SW = $clog2(MAX_D_STREAK + 1) + 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
   localparam logic [SW-1:0] MAX_S    = SW'(MAX_D_STREAK);
   localparam logic          GRANT_I  = 1'b0;
   localparam logic          GRANT_D  = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 grant_q, grant_d;
   logic                 is_write_q, is_write_d;
   logic [WORD_SIZE-1:0] addr_q, addr_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic [WORD_SIZE-1:0] hold_q, hold_d;
   logic [WORD_SIZE-1:0] data1_q, data1_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [SW-1:0]        streak_q, streak_d;

   logic req_d_s;
   logic addr_match_s;
   logic other_req_s;
   logic start_s;
   logic pick_d_s;
   logic strobe_s;
   logic d2_drive_s;

   // Data port wins unless the fetch has already been passed over too often.
   function automatic logic pick_data(input logic req_i, input logic req_d,
                                      input logic [SW-1:0] streak);
      return req_d && !(req_i && (streak >= MAX_S));
   endfunction

   assign req_d_s      = readM2 || writeM2;
   assign addr_match_s = (address1 == addr_q);
   // In RESP only the port that was not just served can trigger a direct
   // hand-over; once triggered, both current requests go through arbitration.
   assign other_req_s  = (grant_q == GRANT_D) ? readM1 : req_d_s;
   assign pick_d_s     = pick_data(readM1, req_d_s, streak_q);

   // Next-state, capture and strobe logic.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      is_write_d = is_write_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      hold_d     = hold_q;
      data1_d    = data1_q;
      cnt_d      = cnt_q;
      streak_d   = streak_q;
      start_s    = 1'b0;
      strobe_s   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (readM1 || req_d_s) begin
               start_s = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ACCESS: begin
            if ((grant_q == GRANT_I) && !readM1) begin
               // Fetch flushed: abandon without touching memory.
               state_d = S_IDLE;
            end else if (cnt_q == {CW{1'b0}}) begin
               strobe_s = 1'b1;
               state_d  = S_RESP;
               if (!is_write_q) begin
                  hold_d = mem_rdata;
                  if (grant_q == GRANT_I) begin
                     data1_d = mem_rdata;
                  end else begin
                     data1_d = data1_q;
                  end
               end else begin
                  hold_d = hold_q;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_RESP: begin
            if ((grant_q == GRANT_I) && !addr_match_s) begin
               // Fetch address moved while we were busy: drop this result.
               state_d = S_IDLE;
            end else if (other_req_s) begin
               start_s = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (start_s) begin
         state_d    = S_ACCESS;
         cnt_d      = CNT_LOAD;
         grant_d    = pick_d_s;
         is_write_d = pick_d_s && writeM2;
         addr_d     = pick_d_s ? address2 : address1;
         if (pick_d_s && writeM2) begin
            wdata_d = data2;
         end else begin
            wdata_d = wdata_q;
         end
         if (pick_d_s && readM1) begin
            streak_d = (streak_q >= MAX_S) ? streak_q : streak_q + SW'(1);
         end else begin
            streak_d = {SW{1'b0}};
         end
      end else begin
         grant_d = grant_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q    <= S_IDLE;
         grant_q    <= GRANT_I;
         is_write_q <= 1'b0;
         addr_q     <= {WORD_SIZE{1'b0}};
         wdata_q    <= {WORD_SIZE{1'b0}};
         hold_q     <= {WORD_SIZE{1'b0}};
         data1_q    <= {WORD_SIZE{1'b0}};
         cnt_q      <= {CW{1'b0}};
         streak_q   <= {SW{1'b0}};
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         is_write_q <= is_write_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         hold_q     <= hold_d;
         data1_q    <= data1_d;
         cnt_q      <= cnt_d;
         streak_q   <= streak_d;
      end
   end

   assign d2_drive_s  = (state_q == S_RESP) && (grant_q == GRANT_D) && !is_write_q;
   assign data2       = d2_drive_s ? hold_q : {WORD_SIZE{1'bz}};
   assign data1       = data1_q;
   assign mem_read    = strobe_s && !is_write_q;
   assign mem_write   = strobe_s && is_write_q;
   assign mem_address = addr_q;
   assign mem_wdata   = wdata_q;
   assign M1busy      = readM1 && !((state_q == S_RESP) && (grant_q == GRANT_I) && addr_match_s);
   assign M2busy      = req_d_s && !((state_q == S_RESP) && (grant_q == GRANT_D));

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

   logic        Clk;
   logic        Reset_N;
   logic        readM1;
   logic [15:0] address1;
   logic [15:0] data1;
   logic        M1busy;
   logic        readM2;
   logic        writeM2;
   logic [15:0] address2;
   wire  [15:0] data2;
   logic        M2busy;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   logic        d2_en;
   logic [15:0] d2_val;
   logic [15:0] mem [0:255];

   int checks;
   int failures;

   unified_mem_arbiter #(.WORD_SIZE(16), .LATENCY(4), .MAX_D_STREAK(2)) dut (
      .Clk(Clk), .Reset_N(Reset_N),
      .readM1(readM1), .address1(address1), .data1(data1), .M1busy(M1busy),
      .readM2(readM2), .writeM2(writeM2), .address2(address2), .data2(data2),
      .M2busy(M2busy), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   assign data2     = d2_en ? d2_val : 16'hzzzz;
   assign mem_rdata = mem[mem_address[7:0]];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      if (mem_write) mem[mem_address[7:0]] <= mem_wdata;
   end

   always @(negedge Clk) begin
      checks = checks + 1;
      if (mem_read && mem_write) begin
         failures = failures + 1;
         $display("FAIL both_strobes actual=11 expected=not both high");
      end
   end

   typedef struct {
      logic        rm1;
      logic [15:0] a1;
      logic        rm2;
      logic        rel2;
      logic [15:0] a2;
      logic        m1b;
      logic        m2b;
      logic        rd;
      logic [15:0] d1;
      logic        cd2;
      logic [15:0] d2;
   } vec_t;

   vec_t vecs [19];

   function automatic vec_t mk(logic rm1, logic [15:0] a1, logic rm2, logic rel2,
                               logic [15:0] a2, logic m1b, logic m2b, logic rd,
                               logic [15:0] d1, logic cd2, logic [15:0] d2);
      vec_t v;
      v.rm1 = rm1; v.a1 = a1; v.rm2 = rm2; v.rel2 = rel2; v.a2 = a2;
      v.m1b = m1b; v.m2b = m2b; v.rd = rd; v.d1 = d1; v.cd2 = cd2; v.d2 = d2;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Runs from the current cycle until the given port's busy drops, sampling
   // at negedges; returns at the negedge of the completing cycle.
   task automatic run_until(input logic port_d, output int cyc, output int nrd,
                            output int nwr, output int nbad);
      cyc = -1; nrd = 0; nwr = 0; nbad = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge Clk);
         if (mem_read) nrd++;
         if (mem_write) nwr++;
         if (d2_en && (data2 !== d2_val)) nbad++;
         if (port_d ? !M2busy : !M1busy) begin
            cyc = k;
            break;
         end
         @(posedge Clk); #1;
      end
      if (cyc < 0) begin
         checks = checks + 1;
         failures = failures + 1;
         $display("FAIL timeout port_d=%0d actual=busy expected=done", port_d);
      end
   endtask

   initial begin
      int cyc, nrd, nwr, nbad, ngr;
      logic       gseq [4];
      logic       gexp [4];
      int         gcyc [4];

      checks = 0; failures = 0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h10] = 16'h6A05;
      mem[8'h12] = 16'h2222;
      mem[8'h14] = 16'h7E7E;
      mem[8'h20] = 16'h1357;

      Reset_N = 1'b0; readM1 = 1'b1; address1 = 16'h0; readM2 = 1'b0;
      writeM2 = 1'b0; address2 = 16'h0; d2_en = 1'b0; d2_val = 16'h0;

      // reset state
      #2;
      chk("rst_m1busy_follows", {31'd0, M1busy}, 32'd1);
      chk("rst_m2busy", {31'd0, M2busy}, 32'd0);
      chk("rst_data1", {16'd0, data1}, 32'd0);
      chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
      chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
      readM1 = 1'b0;
      repeat (3) @(negedge Clk);
      Reset_N = 1'b1;
      @(posedge Clk); #1;

      // single fetch, then simultaneous requests (D first, then I directly)
      for (int i = 0; i < 4; i++) vecs[i] = mk(1'b1, 16'h10, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
      vecs[4]  = mk(1'b1, 16'h10, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'h0,    1'b0, 16'h0);
      vecs[5]  = mk(1'b1, 16'h10, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h6A05, 1'b0, 16'h0);
      vecs[6]  = mk(1'b0, 16'h10, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h6A05, 1'b0, 16'h0);
      for (int i = 7; i < 11; i++) vecs[i] = mk(1'b1, 16'h12, 1'b1, 1'b0, 16'h20, 1'b1, 1'b1, 1'b0, 16'h6A05, 1'b0, 16'h0);
      vecs[11] = mk(1'b1, 16'h12, 1'b1, 1'b0, 16'h20, 1'b1, 1'b1, 1'b1, 16'h6A05, 1'b0, 16'h0);
      vecs[12] = mk(1'b1, 16'h12, 1'b1, 1'b1, 16'h20, 1'b1, 1'b0, 1'b0, 16'h6A05, 1'b1, 16'h1357);
      for (int i = 13; i < 16; i++) vecs[i] = mk(1'b1, 16'h12, 1'b0, 1'b0, 16'h20, 1'b1, 1'b0, 1'b0, 16'h6A05, 1'b0, 16'h0);
      vecs[16] = mk(1'b1, 16'h12, 1'b0, 1'b0, 16'h20, 1'b1, 1'b0, 1'b1, 16'h6A05, 1'b0, 16'h0);
      vecs[17] = mk(1'b1, 16'h12, 1'b0, 1'b0, 16'h20, 1'b0, 1'b0, 1'b0, 16'h2222, 1'b0, 16'h0);
      vecs[18] = mk(1'b0, 16'h12, 1'b0, 1'b0, 16'h20, 1'b0, 1'b0, 1'b0, 16'h2222, 1'b0, 16'h0);

      for (int i = 0; i < 19; i++) begin
         readM1 = vecs[i].rm1; address1 = vecs[i].a1;
         readM2 = vecs[i].rm2; address2 = vecs[i].a2; writeM2 = 1'b0;
         @(negedge Clk);
         chk($sformatf("vec%0d_m1busy", i), {31'd0, M1busy}, {31'd0, vecs[i].m1b});
         chk($sformatf("vec%0d_m2busy", i), {31'd0, M2busy}, {31'd0, vecs[i].m2b});
         chk($sformatf("vec%0d_mem_read", i), {31'd0, mem_read}, {31'd0, vecs[i].rd});
         chk($sformatf("vec%0d_mem_write", i), {31'd0, mem_write}, 32'd0);
         chk($sformatf("vec%0d_data1", i), {16'd0, data1}, {16'd0, vecs[i].d1});
         if (vecs[i].cd2) chk($sformatf("vec%0d_data2", i), {16'd0, data2}, {16'd0, vecs[i].d2});
         if (vecs[i].rel2) readM2 = 1'b0;
         @(posedge Clk); #1;
      end

      // starvation guard: fetch and data both held, expect D, D, I, D
      gexp[0] = 1'b1; gexp[1] = 1'b1; gexp[2] = 1'b0; gexp[3] = 1'b1;
      readM1 = 1'b1; address1 = 16'h10; readM2 = 1'b1; address2 = 16'h20;
      ngr = 0;
      for (int k = 0; k < 60 && ngr < 4; k++) begin
         @(negedge Clk);
         if (!M1busy || !M2busy) begin
            gseq[ngr] = !M2busy;
            gcyc[ngr] = k;
            if (!M2busy) chk("starve_data2", {16'd0, data2}, 32'h1357);
            else         chk("starve_data1", {16'd0, data1}, 32'h6A05);
            ngr++;
            if (ngr == 4) begin
               readM1 = 1'b0; readM2 = 1'b0;
            end
         end
         @(posedge Clk); #1;
      end
      chk("starve_grant_count", ngr, 32'd4);
      for (int g = 0; g < 4 && g < ngr; g++) begin
         chk($sformatf("starve_grant%0d_is_d", g), {31'd0, gseq[g]}, {31'd0, gexp[g]});
         chk($sformatf("starve_grant%0d_cycle", g), gcyc[g], 5 * (g + 1));
      end

      // write then read back
      writeM2 = 1'b1; address2 = 16'h40; d2_val = 16'hBEEF; d2_en = 1'b1;
      run_until(1'b1, cyc, nrd, nwr, nbad);
      chk("wr_cycles", cyc, 32'd5);
      chk("wr_strobes", nwr, 32'd1);
      chk("wr_no_read", nrd, 32'd0);
      chk("wr_data2_undriven", nbad, 32'd0);
      @(posedge Clk); #1;
      writeM2 = 1'b0; d2_en = 1'b0;
      chk("wr_mem_content", {16'd0, mem[8'h40]}, 32'hBEEF);
      readM2 = 1'b1;
      run_until(1'b1, cyc, nrd, nwr, nbad);
      chk("rd_cycles", cyc, 32'd5);
      chk("rd_strobes", nrd, 32'd1);
      chk("rd_data2", {16'd0, data2}, 32'hBEEF);
      @(posedge Clk); #1;
      readM2 = 1'b0;

      // fetch abort in cycle 2, then a fresh fetch from IDLE
      readM1 = 1'b1; address1 = 16'h10;
      nrd = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 2) readM1 = 1'b0;
         @(negedge Clk);
         if (mem_read) nrd++;
         @(posedge Clk); #1;
      end
      chk("abort_no_read", nrd, 32'd0);
      readM1 = 1'b1; address1 = 16'h12;
      run_until(1'b0, cyc, nrd, nwr, nbad);
      chk("after_abort_cycles", cyc, 32'd5);
      chk("after_abort_data1", {16'd0, data1}, 32'h2222);
      @(posedge Clk); #1;
      readM1 = 1'b0;
      @(posedge Clk); #1;

      // address change before RESP: discard, refetch new address
      readM1 = 1'b1; address1 = 16'h10;
      repeat (3) begin @(posedge Clk); #1; end
      address1 = 16'h14;
      run_until(1'b0, cyc, nrd, nwr, nbad);
      chk("addrchg_cycles", cyc, 32'd8);
      chk("addrchg_reads", nrd, 32'd2);
      chk("addrchg_data1", {16'd0, data1}, 32'h7E7E);
      @(posedge Clk); #1;
      readM1 = 1'b0;
      @(posedge Clk); #1;

      // reset in cycle 3 of a write access
      writeM2 = 1'b1; address2 = 16'h44; d2_val = 16'h5555; d2_en = 1'b1;
      repeat (3) begin @(posedge Clk); #1; end
      #2 Reset_N = 1'b0;
      #1;
      chk("arst_mem_write", {31'd0, mem_write}, 32'd0);
      chk("arst_mem_read", {31'd0, mem_read}, 32'd0);
      chk("arst_data1", {16'd0, data1}, 32'd0);
      chk("arst_m2busy_follows", {31'd0, M2busy}, 32'd1);
      chk("arst_m1busy", {31'd0, M1busy}, 32'd0);
      chk("arst_mem_address", {16'd0, mem_address}, 32'd0);
      chk("arst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
      writeM2 = 1'b0; d2_en = 1'b0;
      nwr = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge Clk);
         if (mem_write) nwr++;
         if (k == 1) Reset_N = 1'b1;
      end
      chk("arst_no_write", nwr, 32'd0);
      chk("arst_mem_untouched", {16'd0, mem[8'h44]}, 32'd0);
      @(posedge Clk); #1;
      readM1 = 1'b1; address1 = 16'h10;
      run_until(1'b0, cyc, nrd, nwr, nbad);
      chk("post_rst_cycles", cyc, 32'd5);
      chk("post_rst_data1", {16'd0, data1}, 32'h6A05);
      @(posedge Clk); #1;
      readM1 = 1'b0;
      repeat (2) @(posedge Clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-ported, multi-cycle main memory between the pipeline's instruction-fetch port (M1) and data port (M2). It converts each port's level request into a timed memory access and returns busy flags that stall the requesting pipeline stage. It sits between the datapath's M1/M2 interface and a unified memory array with a combinational read and a synchronous write. Arbitration gives the data port priority, with a starvation guard so instruction fetch always makes progress.

## Interface
- WORD_SIZE, 16, data and address width
- LATENCY, 4, memory access cycles per transaction (≥1)
- MAX_D_STREAK, 2, consecutive data grants allowed while a fetch is pending before the fetch is forced through
- Clk  input  1  single clock, rising edge
- Reset_N  input  1  asynchronous, active-low reset
- readM1  input  1  instruction-fetch request (level)
- address1  input  WORD_SIZE  fetch address
- data1  output  WORD_SIZE  fetched instruction; valid while M1busy is low in the RESP state
- M1busy  output  1  fetch not yet complete
- readM2  input  1  data read request (level)
- writeM2  input  1  data write request (level); wins if asserted together with readM2
- address2  input  WORD_SIZE  data address
- data2  inout  WORD_SIZE  write data from the datapath; read data driven by the arbiter
- M2busy  output  1  data access not yet complete
- mem_read  output  1  one-cycle memory read strobe
- mem_write  output  1  one-cycle memory write strobe
- mem_address  output  WORD_SIZE  memory address
- mem_wdata  output  WORD_SIZE  memory write data
- mem_rdata  input  WORD_SIZE  memory read data, combinational from mem_address

## Operation

**State machine.** States are IDLE, ACCESS and RESP.
- Registers: `grant` (I or D), `is_write`, captured address, captured write data, read-data hold register, down-counter `cnt` of width clog2(LATENCY)+1, and `d_streak`.

**IDLE**
- If a request is pending, arbitrate, capture address and write data, load `cnt`=LATENCY-1, and go to ACCESS.
- Arbitration when both ports request: D wins unless `d_streak` ≥ MAX_D_STREAK, in which case I wins.
- `d_streak` increments on a D grant while readM1 is high, saturating at MAX_D_STREAK.
- `d_streak` clears on an I grant, or on a D grant while readM1 is low.

**ACCESS**
- `cnt` decrements each cycle.
- In the cycle with `cnt`==0:
  - mem_read or mem_write pulses for one cycle with the captured address and data.
  - For a read, mem_rdata is latched into the hold register.
  - The next state is RESP.
- Fetch abort: if readM1 drops during an I access, return to IDLE next edge with no memory strobe. This covers branch flushes.
- The data port may not abort; readM2/writeM2 are held by the requester until M2busy is low.

**RESP** (one cycle)
- The granted port's busy is low.
- For an I grant, data1 equals the hold register.
- For a D read, data2 is driven with the hold register; otherwise data2 is high-Z.
- If an I grant finds address1 ≠ captured address, the result is discarded: M1busy stays high and the state returns to IDLE.
- Next state:
  - If the non-served port is requesting, arbitrate it directly (same priority rules) and go to ACCESS.
  - Otherwise go to IDLE.

**Busy and data outputs**
- M1busy = readM1 && !(RESP && grant==I && address match).
- M2busy = (readM2 || writeM2) && !(RESP && grant==D).
- data1 outside RESP holds its last value.

**Reset**
- Asynchronous, from any state.
- State becomes IDLE; `cnt`, `d_streak`, hold and captured registers become 0; grant becomes I.
- mem_read and mem_write are 0, and an in-flight write is dropped.
- data2 is high-Z and data1 is 0.
- Busy outputs follow requests combinationally (request high means busy high).

## Timing
- A request is sampled in IDLE in cycle t.
- ACCESS occupies cycles t+1 through t+LATENCY.
- The memory strobe occurs in cycle t+LATENCY.
- RESP is cycle t+LATENCY+1, with busy low and data valid.
- The requester latches at the end of RESP. With LATENCY=4, busy is high for 5 cycles.
- Back-to-back across ports: the second port's ACCESS starts the cycle after the first port's RESP, with no IDLE gap.
- The same port's next request is seen in IDLE the cycle after RESP.
- mem_read and mem_write are never both high; at most one strobe occurs per transaction.

## Test plan
- Single fetch, LATENCY=4: readM1=1, address1=0x0010, mem[0x10]=0x6A05. M1busy is high for cycles 0–4 and low in cycle 5 with data1=0x6A05; mem_read pulses once, in cycle 4.
- Simultaneous requests: readM1 and readM2 both rise in cycle 0. D is served first (M2busy low in cycle 5, data2=mem[address2]), then I directly (M1busy low in cycle 10), with no IDLE cycle between.
- Starvation guard, MAX_D_STREAK=2: readM1 held high and 3 consecutive data requests. The order of grants is D, D, I, D.
- Write then read: writeM2=1, address2=0x0040, data2=0xBEEF, then readM2 to 0x0040. mem_write pulses once and the read returns 0xBEEF; data2 is never driven by the arbiter during the write.
- Fetch abort and address change:
  - readM1 dropped in cycle 2: no mem_read pulse, state back to IDLE.
  - address1 changed before RESP: M1busy stays high and the new address completes after a fresh access.
- Reset mid-ACCESS of a write: Reset_N low in cycle 3. No mem_write pulse, state is IDLE, and all outputs are at reset values immediately (asynchronous).
